// File: rtl/margin_pkg.sv
// Shared types for the margin pipeline: score/index widths and the top-2 tuple.
// MRGN_ARGMAX_EN adds the top1 class index (idx1) to each tuple.
package margin_pkg;
    localparam int N_CLASSES   = 8;
    localparam int PROB_W      = 32;
    localparam int DATA_LENGTH = 160;
    localparam int IDX_W       = $clog2(DATA_LENGTH);
    localparam int CLS_W       = $clog2(N_CLASSES);
    localparam int DIN_W       = N_CLASSES * PROB_W;

    typedef struct packed {
        logic [PROB_W-1:0] max1;
        logic [PROB_W-1:0] max2;
`ifdef MRGN_ARGMAX_EN
        logic [CLS_W-1:0]  idx1;
`endif
    } top2_t;

    localparam top2_t TOP2_EMPTY = '0;

    // A single class score seen as a tuple with no runner-up yet.
    function automatic top2_t leaf_tuple(input logic [PROB_W-1:0] score, input int cls);
        top2_t t;
        t = TOP2_EMPTY;
        t.max1 = score;
`ifdef MRGN_ARGMAX_EN
        t.idx1 = CLS_W'(cls);
`endif
        return t;
    endfunction
endpackage

// File: rtl/margin_pipeline_if.sv
// Sample-in / margin-out bundle between the controller (master) and the pipeline (slave).
// Argmax exists only when MRGN_ARGMAX_EN is defined.
interface margin_pipeline_if;
    logic                          En;
    logic                          Clear;
    logic                          In_Valid;
    logic [margin_pkg::DIN_W-1:0]  Din;
    logic                          Out_Valid;
    logic [margin_pkg::PROB_W-1:0] Margin;
    logic [margin_pkg::IDX_W-1:0]  Out_Indx;
`ifdef MRGN_ARGMAX_EN
    logic [margin_pkg::CLS_W-1:0]  Argmax;
`endif

    modport master (
        output En, Clear, In_Valid, Din,
        input  Out_Valid, Margin, Out_Indx
`ifdef MRGN_ARGMAX_EN
        , Argmax
`endif
    );

    modport slave (
        input  En, Clear, In_Valid, Din,
        output Out_Valid, Margin, Out_Indx
`ifdef MRGN_ARGMAX_EN
        , Argmax
`endif
    );
endinterface

// File: rtl/top2_merge.sv
// Combinational merge of two top-2 tuples; a holds the lower classes and wins ties.
module top2_merge
    import margin_pkg::*;
(
    input  top2_t a,
    input  top2_t b,
    output top2_t y
);
    always_comb begin
        y = TOP2_EMPTY;
        if (a.max1 >= b.max1) begin
            y      = a;
            y.max2 = (b.max1 > a.max2) ? b.max1 : a.max2;
        end else begin
            y      = b;
            y.max2 = (a.max1 > b.max2) ? a.max1 : b.max2;
        end
    end
endmodule

// File: rtl/margin_pipeline.sv
// Three-stage top1-top2 margin tree (8 -> 4 -> 2 -> 1) with per-sample index tagging.
// Optional MRGN_ARGMAX_EN carries the winning class to the Argmax output.
module margin_pipeline
    import margin_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    margin_pipeline_if.slave  bus
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LENGTH - 1);

    top2_t leaf   [N_CLASSES];
    top2_t s1_next[4];
    top2_t s1_q   [4];
    top2_t s2_next[2];
    top2_t s2_q   [2];
    top2_t s3_next;

    logic             s1_valid, s2_valid, out_valid;
    logic [IDX_W-1:0] indx_cnt, s1_indx, s2_indx, out_indx;
    logic [PROB_W-1:0] margin;
`ifdef MRGN_ARGMAX_EN
    logic [CLS_W-1:0] argmax;
`endif

    for (genvar c = 0; c < N_CLASSES; c++) begin : g_leaf
        assign leaf[c] = leaf_tuple(bus.Din[c*PROB_W +: PROB_W], c);
    end

    for (genvar p = 0; p < 4; p++) begin : g_s1
        top2_merge u_merge (.a(leaf[2*p]), .b(leaf[2*p+1]), .y(s1_next[p]));
    end

    for (genvar p = 0; p < 2; p++) begin : g_s2
        top2_merge u_merge (.a(s1_q[2*p]), .b(s1_q[2*p+1]), .y(s2_next[p]));
    end

    top2_merge u_s3 (.a(s2_q[0]), .b(s2_q[1]), .y(s3_next));

    // Data registers load only behind a valid, so bubbles leave the outputs untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            indx_cnt  <= '0;
            s1_indx   <= '0;
            s2_indx   <= '0;
            out_indx  <= '0;
            margin    <= '0;
`ifdef MRGN_ARGMAX_EN
            argmax    <= '0;
`endif
            for (int i = 0; i < 4; i++) s1_q[i] <= TOP2_EMPTY;
            for (int i = 0; i < 2; i++) s2_q[i] <= TOP2_EMPTY;
        end else if (bus.Clear) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            indx_cnt  <= '0;
        end else if (bus.En) begin
            s1_valid  <= bus.In_Valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (bus.In_Valid) begin
                s1_q     <= s1_next;
                s1_indx  <= indx_cnt;
                indx_cnt <= (indx_cnt == IDX_LAST) ? '0 : indx_cnt + 1'b1;
            end
            if (s1_valid) begin
                s2_q    <= s2_next;
                s2_indx <= s1_indx;
            end
            if (s2_valid) begin
                margin   <= s3_next.max1 - s3_next.max2;
                out_indx <= s2_indx;
`ifdef MRGN_ARGMAX_EN
                argmax   <= s3_next.idx1;
`endif
            end
        end
    end

    assign bus.Out_Valid = out_valid;
    assign bus.Margin    = margin;
    assign bus.Out_Indx  = out_indx;
`ifdef MRGN_ARGMAX_EN
    assign bus.Argmax    = argmax;
`endif
endmodule

// File: tb/tb_margin_pipeline.sv
// Scoreboard bench for margin_pipeline: driver pushes reference results, monitor pops on Out_Valid.
// Argmax is checked when MRGN_ARGMAX_EN is defined.
module tb_margin_pipeline;
    import margin_pkg::*;

    typedef struct {
        logic [PROB_W-1:0] margin;
        logic [IDX_W-1:0]  indx;
        logic [CLS_W-1:0]  argmax;
        int                due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    margin_pipeline_if bus();

    margin_pipeline dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   model_idx = 0;
    int   en_edges = 0;
    bit   fresh = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: highest score (lowest class on ties) minus the best of the rest.
    function automatic exp_t ref_model(input logic [DIN_W-1:0] din);
        exp_t e;
        logic [PROB_W-1:0] s[N_CLASSES];
        int best = 0;
        logic [PROB_W-1:0] second = '0;
        for (int c = 0; c < N_CLASSES; c++) s[c] = din[c*PROB_W +: PROB_W];
        for (int c = 1; c < N_CLASSES; c++) if (s[c] > s[best]) best = c;
        for (int c = 0; c < N_CLASSES; c++) if (c != best && s[c] > second) second = s[c];
        e.margin = s[best] - second;
        e.argmax = CLS_W'(best);
        e.indx   = '0;
        e.due    = 0;
        return e;
    endfunction

    function automatic logic [DIN_W-1:0] rand_din();
        logic [DIN_W-1:0] d;
        int mode = $urandom_range(0, 3);
        for (int c = 0; c < N_CLASSES; c++)
            d[c*PROB_W +: PROB_W] = (mode == 0) ? PROB_W'($urandom_range(0, 3)) : PROB_W'($urandom);
        return d;
    endfunction

    task automatic drive(input logic en, input logic clr, input logic iv, input logic [DIN_W-1:0] d);
        exp_t e;
        bus.En = en; bus.Clear = clr; bus.In_Valid = iv; bus.Din = d;
        @(posedge clk);
        if (clr) begin
            sb.delete();
            model_idx = 0;
            fresh = 1'b0;
        end else begin
            fresh = en;
            if (en) begin
                en_edges++;
                if (iv) begin
                    e = ref_model(d);
                    e.indx = IDX_W'(model_idx);
                    e.due  = en_edges + 2;
                    sb.push_back(e);
                    model_idx = (model_idx + 1) % DATA_LENGTH;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.Out_Valid), 64'd0);
        check({tag, "_margin"},    64'(bus.Margin),    64'd0);
        check({tag, "_indx"},      64'(bus.Out_Indx),  64'd0);
`ifdef MRGN_ARGMAX_EN
        check({tag, "_argmax"},    64'(bus.Argmax),    64'd0);
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fresh) begin
                if (bus.Out_Valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 64'(bus.Out_Valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("latency_edges", 64'(en_edges), 64'(e.due));
                        check("margin", 64'(bus.Margin), 64'(e.margin));
                        check("out_indx", 64'(bus.Out_Indx), 64'(e.indx));
`ifdef MRGN_ARGMAX_EN
                        check("argmax", 64'(bus.Argmax), 64'(e.argmax));
`endif
                        last_exp = e;
                    end
                end else if (sb.size() > 0 && sb[0].due <= en_edges) begin
                    check("missing_out_valid", 64'(bus.Out_Valid), 64'd1);
                    void'(sb.pop_front());
                end
            end else if (bus.Out_Valid) begin
                check("hold_margin", 64'(bus.Margin), 64'(last_exp.margin));
                check("hold_indx", 64'(bus.Out_Indx), 64'(last_exp.indx));
            end
        end
    end

    initial begin
        logic [DIN_W-1:0] d;
        bus.En = 1'b0; bus.Clear = 1'b0; bus.In_Valid = 1'b0; bus.Din = '0;
        #12;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: clear winner of 7 by margin 7, then a tie between classes 2 and 6.
        d = '0;
        d[7*PROB_W +: PROB_W] = 10;
        d[6*PROB_W +: PROB_W] = 3;
        d[0*PROB_W +: PROB_W] = 1;
        drive(1'b1, 1'b0, 1'b1, d);
        idle(3);
        d = '0;
        d[2*PROB_W +: PROB_W] = 5;
        d[6*PROB_W +: PROB_W] = 5;
        drive(1'b1, 1'b0, 1'b1, d);
        idle(3);

        // Clear with En low, then one full batch plus one to see the index wrap.
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < DATA_LENGTH + 1; i++) drive(1'b1, 1'b0, 1'b1, rand_din());
        idle(3);

        // Stall mid-stream: In_Valid held high while En is low must not admit samples.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, rand_din());
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, rand_din());
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, rand_din());
        idle(4);

        // Clear with two samples in flight and a sample offered in the same cycle.
        drive(1'b1, 1'b0, 1'b1, rand_din());
        drive(1'b1, 1'b0, 1'b1, rand_din());
        drive(1'b1, 1'b1, 1'b1, rand_din());
        drive(1'b1, 1'b0, 1'b1, rand_din());
        idle(4);

        // Async reset between edges with samples in flight.
        drive(1'b1, 1'b0, 1'b1, rand_din());
        drive(1'b1, 1'b0, 1'b1, rand_din());
        #1 rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        sb.delete();
        model_idx = 0;
        fresh = 1'b0;
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, rand_din());
        idle(4);

        // Random mix of stalls, bubbles and occasional clears.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 9) < 7), rand_din());
        idle(6);

        check("drain_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
